apb_regfile_slave: RTL and testbench

- APB completer (slave) for the cat recognizer: the responder to the APB write/read traffic the bench initiator drives.
- Holds a control/status register at address 0 and a file_length-word image/weight memory at addresses 1..file_length.
- Starts the recognition core on a CTRL write and reports busy/done/result on CTRL reads.
- Gives the core a private 1-cycle-latency read port into the memory.

---
 rtl/apb_regfile_slave.sv | 79 +++++++
 tb/tb_apb_regfile_slave.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB completer holding CTRL (addr 0) and a file_length-word image memory for the recognition core.
// Define PSLVERR_EN to add the PSLVERR error response output.
module apb_regfile_slave #(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 13,
  parameter int file_length     = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [Amba_Addr_Depth-1:0] PADDR,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [Amba_Word-1:0]       PWDATA,
  output logic [Amba_Word-1:0]       PRDATA,
`ifdef PSLVERR_EN
  output logic                       PSLVERR,
`endif
  output logic                       core_start,
  input  logic                       core_done,
  input  logic                       core_result,
  input  logic [Amba_Addr_Depth-1:0] core_rd_addr,
  output logic [Amba_Word-1:0]       core_rd_data
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam logic [Amba_Addr_Depth-1:0] Last = Amba_Addr_Depth'(file_length);
  state_t state_q, state_d;
  logic [Amba_Word-1:0] mem [1:file_length];
  logic [Amba_Word-1:0] apb_rd_q, apb_rd_d, core_rd_data_q, core_rd_data_d;
  logic busy_q, busy_d, done_q, done_d, result_q, result_d, start_q, start_d;
  logic acc, ctrl_wr, mem_wr, finish, apb_hit, core_hit;
  assign apb_hit      = PADDR != '0 && PADDR <= Last;
  assign core_hit     = core_rd_addr != '0 && core_rd_addr <= Last;
  assign core_start   = start_q;
  assign core_rd_data = core_rd_data_q;
  // A cycle is a real ACCESS only when the previous cycle was SETUP; stuck or unprefixed enables are ignored.
  always_comb begin
    state_d        = !PSEL ? IDLE : !PENABLE ? SETUP : state_q == SETUP ? ACCESS : IDLE;
    acc            = state_q == SETUP && PSEL && PENABLE;
    ctrl_wr        = acc && PWRITE && PADDR == '0;
    mem_wr         = acc && PWRITE && apb_hit && !busy_q;
    finish         = core_done && busy_q;
    start_d        = ctrl_wr && PWDATA[0] && !busy_q && !core_done;
    busy_d         = finish ? 1'b0 : start_d ? 1'b1 : busy_q;
    done_d         = finish ? 1'b1 : (start_d || (ctrl_wr && !PWDATA[0])) ? 1'b0 : done_q;
    result_d       = finish ? core_result : result_q;
    apb_rd_d       = (PSEL && !PENABLE) ? (apb_hit ? mem[PADDR] : '0) : apb_rd_q;
    core_rd_data_d = core_hit ? mem[core_rd_addr] : '0;
    PRDATA         = !(acc && !PWRITE) ? '0 :
                     PADDR == '0 ? {{(Amba_Word-3){1'b0}}, result_q, done_q, busy_q} : apb_rd_q;
  end
`ifdef PSLVERR_EN
  assign PSLVERR = acc && ((PADDR != '0 && !apb_hit) || (PWRITE && apb_hit && busy_q) ||
                           (ctrl_wr && PWDATA[0] && busy_q));
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      apb_rd_q       <= '0;
      core_rd_data_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_q       <= 1'b0;
      start_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      apb_rd_q       <= apb_rd_d;
      core_rd_data_q <= core_rd_data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      result_q       <= result_d;
      start_q        <= start_d;
    end
  end
  // Memory is never cleared by reset; a write pending at a reset edge is discarded.
  always_ff @(posedge clk) begin
    if (mem_wr && !rst) mem[PADDR] <= PWDATA;
  end
endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: directed plus random APB/core traffic checked against a behavioural register-file model.
module tb_apb_regfile_slave;
  localparam int W = 24;
  localparam int A = 13;
  localparam int N = 4096;
  logic clk = 1'b0;
  logic rst, PSEL, PENABLE, PWRITE, core_start, core_done, core_result, pslverr;
  logic [A-1:0] PADDR, core_rd_addr;
  logic [W-1:0] PWDATA, PRDATA, core_rd_data;
  int total = 0;
  int bad = 0;
  logic [W-1:0] mem_m [0:N];
  logic busy_m = 1'b0, done_m = 1'b0, result_m = 1'b0;

  apb_regfile_slave #(.Amba_Word(W), .Amba_Addr_Depth(A), .file_length(N)) dut (
    .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA),
`ifdef PSLVERR_EN
    .PSLVERR(pslverr),
`endif
    .core_start(core_start), .core_done(core_done), .core_result(core_result),
    .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] m_read(input int addr);
    if (addr == 0) return W'({result_m, done_m, busy_m});
    return (addr <= N) ? mem_m[addr] : '0;
  endfunction

  function automatic logic [W-1:0] m_core(input int addr);
    return (addr >= 1 && addr <= N) ? mem_m[addr] : '0;
  endfunction

  function automatic logic m_err(input int addr, input logic wr, input logic [W-1:0] data);
    return addr > N || (wr && busy_m && (addr != 0 || data[0]));
  endfunction

  task automatic m_write(input int addr, input logic [W-1:0] data);
    if (addr == 0) begin
      if (!data[0]) done_m = 1'b0;
      else if (!busy_m) begin busy_m = 1'b1; done_m = 1'b0; end
    end else if (addr <= N && !busy_m) mem_m[addr] = data;
  endtask

  task automatic apb(input logic wr, input int addr, input logic [W-1:0] data, input bit keep_sel);
    logic e;
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = A'(addr); PWDATA = data;
    @(negedge clk);
    PENABLE = 1'b1;
    #1;
    e = m_err(addr, wr, data);
    if (!wr) check($sformatf("apb_rd[%0d]", addr), PRDATA, m_read(addr));
`ifdef PSLVERR_EN
    check($sformatf("pslverr[%0d]", addr), W'(pslverr), W'(e));
`endif
    @(posedge clk);
    if (wr) m_write(addr, data);
    if (!keep_sel) begin
      @(negedge clk);
      PSEL = 1'b0; PENABLE = 1'b0;
    end
  endtask

  task automatic core_rd(input int addr);
    @(negedge clk);
    core_rd_addr = A'(addr);
    @(negedge clk);
    #1;
    check($sformatf("core_rd[%0d]", addr), core_rd_data, m_core(addr));
  endtask

  initial begin
    int a;
    logic [W-1:0] d;
    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    core_done = 1'b0; core_result = 1'b0; core_rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_prdata", PRDATA, '0);
    check("rst_core_start", W'(core_start), '0);
    check("rst_core_rd_data", core_rd_data, '0);
    apb(1'b0, 0, '0, 1'b0);
    apb(1'b1, 5, 24'hABCDEF, 1'b0);
    apb(1'b0, 5, '0, 1'b0);
    #1;
    check("prdata_idle", PRDATA, '0);
    for (int i = 1; i <= 16; i++) apb(1'b1, i, W'(i), 1'b1);
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
    for (int i = 1; i <= 16; i++) core_rd(i);
    // Enable without a SETUP phase must not commit nor drive read data.
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 13'd7; PWDATA = 24'h777777;
    #1;
    check("no_setup_prdata", PRDATA, '0);
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
    apb(1'b0, 7, '0, 1'b0);
    // ACCESS held for an extra edge commits only the first word.
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 13'd8; PWDATA = 24'h888888;
    @(negedge clk);
    PENABLE = 1'b1;
    @(posedge clk);
    m_write(8, 24'h888888);
    @(negedge clk);
    PWDATA = 24'h111111;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
    apb(1'b0, 8, '0, 1'b0);
    for (int i = 17; i <= 32; i++) apb(1'b1, i, W'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(1, 32);
      d = W'($urandom);
      case ($urandom_range(0, 4))
        0, 1: apb(1'b1, a, d, $urandom_range(0, 1) == 1);
        2: apb(1'b0, a, '0, 1'b0);
        3: core_rd(a);
        default: apb(1'b0, $urandom_range(N + 1, 8191), '0, 1'b0);
      endcase
    end
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
    apb(1'b1, 0, 24'h000001, 1'b0);
    #1;
    check("start_pulse", W'(core_start), 1);
    @(negedge clk);
    #1;
    check("start_one_cycle", W'(core_start), 0);
    apb(1'b0, 0, '0, 1'b0);
    apb(1'b1, 3, 24'h123456, 1'b0);
    apb(1'b0, 3, '0, 1'b0);
    core_rd(3);
    apb(1'b1, 0, 24'h000001, 1'b0);
    #1;
    check("restart_while_busy", W'(core_start), 0);
    @(negedge clk);
    core_done = 1'b1; core_result = 1'b1;
    @(posedge clk);
    busy_m = 1'b0; done_m = 1'b1; result_m = 1'b1;
    @(negedge clk);
    core_done = 1'b0; core_result = 1'b0;
    apb(1'b0, 0, '0, 1'b0);
    apb(1'b1, 0, 24'h000000, 1'b0);
    apb(1'b0, 0, '0, 1'b0);
    apb(1'b1, N, 24'hFFFFFF, 1'b0);
    apb(1'b0, N, '0, 1'b0);
    core_rd(N);
    apb(1'b1, N + 1, 24'h5A5A5A, 1'b0);
    apb(1'b0, N + 1, '0, 1'b0);
    core_rd(N + 1);
    apb(1'b1, 0, 24'h000001, 1'b0);
    #1;
    check("start_before_rst", W'(core_start), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    busy_m = 1'b0; done_m = 1'b0; result_m = 1'b0;
    apb(1'b0, 0, '0, 1'b0);
    apb(1'b1, 0, 24'h000001, 1'b0);
    #1;
    check("start_after_rst", W'(core_start), 1);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
